// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes and control-word bit layout for the SAP control unit
package sap_pkg;

    localparam int CTRL_W = 16;

    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    localparam logic [CTRL_W-1:0] CTRL_HALT_WORD = 16'h8000;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

endpackage

// File: rtl/sap_microcode_rom.sv
// rtl/sap_microcode_rom.sv - combinational microcode: (opcode, step, flags) -> control word, last-step
module sap_microcode_rom
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [STEP_W-1:0]   step_i,
    input  logic                carry_i,
    input  logic                zero_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic                last_o
);

    localparam logic [STEP_W-1:0] T0 = '0;
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

    logic [3:0] op;

    always_comb begin
        ctrl_o = '0;
        last_o = 1'b0;
        // Opcodes wider than 4 bits with any upper bit set are not defined and run as NOP.
        op     = ((opcode_i >> 4) == '0) ? opcode_i[3:0] : OP_NOP;

        if (step_i == T0) begin
            ctrl_o[CTRL_CO] = 1'b1;
            ctrl_o[CTRL_MI] = 1'b1;
        end else if (step_i == T1) begin
            ctrl_o[CTRL_RO] = 1'b1;
            ctrl_o[CTRL_II] = 1'b1;
            ctrl_o[CTRL_CE] = 1'b1;
        end else begin
            case (op)
                OP_LDA: begin
                    if (step_i == T2) begin
                        ctrl_o[CTRL_IO] = 1'b1;
                        ctrl_o[CTRL_MI] = 1'b1;
                    end else if (step_i == T3) begin
                        ctrl_o[CTRL_RO] = 1'b1;
                        ctrl_o[CTRL_AI] = 1'b1;
                        last_o          = 1'b1;
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (step_i == T2) begin
                        ctrl_o[CTRL_IO] = 1'b1;
                        ctrl_o[CTRL_MI] = 1'b1;
                    end else if (step_i == T3) begin
                        ctrl_o[CTRL_RO] = 1'b1;
                        ctrl_o[CTRL_BI] = 1'b1;
                    end else if (step_i == T4) begin
                        ctrl_o[CTRL_EO] = 1'b1;
                        ctrl_o[CTRL_AI] = 1'b1;
                        ctrl_o[CTRL_FI] = 1'b1;
                        ctrl_o[CTRL_SU] = (op == OP_SUB);
                        last_o          = 1'b1;
                    end
                end
                OP_STA: begin
                    if (step_i == T2) begin
                        ctrl_o[CTRL_IO] = 1'b1;
                        ctrl_o[CTRL_MI] = 1'b1;
                    end else if (step_i == T3) begin
                        ctrl_o[CTRL_AO] = 1'b1;
                        ctrl_o[CTRL_RI] = 1'b1;
                        last_o          = 1'b1;
                    end
                end
                OP_LDI: begin
                    if (step_i == T2) begin
                        ctrl_o[CTRL_IO] = 1'b1;
                        ctrl_o[CTRL_AI] = 1'b1;
                        last_o          = 1'b1;
                    end
                end
                OP_JMP, OP_JC, OP_JZ: begin
                    if (step_i == T2) begin
                        if (op == OP_JMP || (op == OP_JC && carry_i) || (op == OP_JZ && zero_i)) begin
                            ctrl_o[CTRL_IO] = 1'b1;
                            ctrl_o[CTRL_J]  = 1'b1;
                        end
                        last_o = 1'b1;
                    end
                end
                OP_OUT: begin
                    if (step_i == T2) begin
                        ctrl_o[CTRL_AO] = 1'b1;
                        ctrl_o[CTRL_OI] = 1'b1;
                        last_o          = 1'b1;
                    end
                end
                OP_HLT: begin
                    if (step_i == T2) begin
                        ctrl_o[CTRL_HLT] = 1'b1;
                        last_o           = 1'b1;
                    end
                end
                default: begin
                    last_o = (step_i == T2);
                end
            endcase
        end
    end

endmodule

// File: rtl/sap_control_unit.sv
// rtl/sap_control_unit.sv - IR, flags, microstep sequencer, sticky halt and single-step handshake
module sap_control_unit
    import sap_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 4,
    parameter int STEPS    = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            bus_in,
    input  logic                         carry_in,
    input  logic                         zero_in,
    input  logic                         step_mode,
    input  logic                         step_req,
    output logic                         step_ack,
    output logic [DATA_W-OPCODE_W-1:0]   operand,
    output logic [CTRL_W-1:0]            ctrl,
    output logic [$clog2(STEPS)-1:0]     step,
    output logic                         halted
);

    localparam int                STEP_W    = $clog2(STEPS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    logic [STEP_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              halted_q, halted_d;
    logic              ack_q, ack_d;
    logic              req_q;

    logic              adv;
    logic              rom_last;
    logic [CTRL_W-1:0] rom_ctrl;
    logic [CTRL_W-1:0] live_ctrl;

    sap_microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W)
    ) u_rom (
        .opcode_i (ir_q[DATA_W-1 -: OPCODE_W]),
        .step_i   (step_q),
        .carry_i  (carry_q),
        .zero_i   (zero_q),
        .ctrl_o   (rom_ctrl),
        .last_o   (rom_last)
    );

    always_comb begin
        // In single-step mode only the cycle that sees a fresh step_req rising edge advances.
        adv       = !halted_q && (step_mode ? (step_req && !req_q) : 1'b1);
        live_ctrl = adv ? rom_ctrl : '0;

        step_d    = step_q;
        ir_d      = ir_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        halted_d  = halted_q;

        if (adv) begin
            step_d = (rom_last || step_q == STEP_LAST) ? '0 : step_q + 1'b1;
            if (rom_ctrl[CTRL_II]) begin
                ir_d = bus_in;
            end
            if (rom_ctrl[CTRL_FI]) begin
                carry_d = carry_in;
                zero_d  = zero_in;
            end
            if (rom_ctrl[CTRL_HLT]) begin
                halted_d = 1'b1;
            end
        end

        if (halted_q) begin
            ack_d = 1'b0;
        end else if (step_mode && adv) begin
            ack_d = 1'b1;
        end else if (!step_req) begin
            ack_d = 1'b0;
        end else begin
            ack_d = ack_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q   <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            step_q   <= step_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
            ack_q    <= ack_d;
            req_q    <= step_req;
        end
    end

    assign ctrl     = reset ? '0 : (halted_q ? CTRL_HALT_WORD : live_ctrl);
    assign step     = step_q;
    assign halted   = halted_q;
    assign step_ack = ack_q;
    assign operand  = ir_q[DATA_W-OPCODE_W-1:0];

endmodule

// File: tb/tb_sap_control_unit.sv
// tb/tb_sap_control_unit.sv - directed table-driven bench for sap_control_unit
module tb_sap_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  bus_in;
    logic        carry_in, zero_in, step_mode, step_req;
    logic        step_ack, halted;
    logic [3:0]  operand;
    logic [15:0] ctrl;
    logic [2:0]  step;

    logic        reset12;
    logic [11:0] bus12;
    logic        c12 = 1'b0, z12 = 1'b0, m12 = 1'b0, r12 = 1'b0;
    logic        ack12, halted12;
    logic [7:0]  operand12;
    logic [15:0] ctrl12;
    logic [2:0]  step12;

    int checks = 0;
    int errors = 0;

    sap_control_unit u_dut (
        .clock     (clock),
        .reset     (reset),
        .bus_in    (bus_in),
        .carry_in  (carry_in),
        .zero_in   (zero_in),
        .step_mode (step_mode),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .operand   (operand),
        .ctrl      (ctrl),
        .step      (step),
        .halted    (halted)
    );

    sap_control_unit #(.DATA_W(12), .OPCODE_W(4), .STEPS(8)) u_dut12 (
        .clock     (clock),
        .reset     (reset12),
        .bus_in    (bus12),
        .carry_in  (c12),
        .zero_in   (z12),
        .step_mode (m12),
        .step_req  (r12),
        .step_ack  (ack12),
        .operand   (operand12),
        .ctrl      (ctrl12),
        .step      (step12),
        .halted    (halted12)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  bus;
        logic        c;
        logic        z;
        logic [2:0]  st;
        logic [15:0] ct;
        logic [3:0]  op;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] b, logic c, logic z, logic [2:0] s, logic [15:0] t, logic [3:0] o);
        vec_t v;
        v.bus = b; v.c = c; v.z = z; v.st = s; v.ct = t; v.op = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] ss_ct[4];
        logic [2:0]  ss_pre[5];
        logic [7:0]  ss_bus[4];
        logic [15:0] fr_ct[4];
        logic [2:0]  hs;
        int          bad;

        reset = 1'b1; reset12 = 1'b1;
        bus_in = '0; carry_in = 0; zero_in = 0; step_mode = 0; step_req = 0; bus12 = '0;

        // Free-run program: LDI, ADD(c=1), JC taken, SUB(z=1), JC not taken, JZ taken, STA, OUT, NOP, LDA, JMP
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h0));
        vecs.push_back(mk(8'h57, 0, 0, 1, 16'h1408, 4'h0));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h0A00, 4'h7));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h7));
        vecs.push_back(mk(8'h2E, 0, 0, 1, 16'h1408, 4'h7));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h4800, 4'hE));
        vecs.push_back(mk(8'h00, 0, 0, 3, 16'h1020, 4'hE));
        vecs.push_back(mk(8'h00, 1, 0, 4, 16'h0281, 4'hE));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'hE));
        vecs.push_back(mk(8'h73, 0, 0, 1, 16'h1408, 4'hE));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h0802, 4'h3));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h3));
        vecs.push_back(mk(8'h31, 0, 0, 1, 16'h1408, 4'h3));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h4800, 4'h1));
        vecs.push_back(mk(8'h00, 0, 0, 3, 16'h1020, 4'h1));
        vecs.push_back(mk(8'h00, 0, 1, 4, 16'h02C1, 4'h1));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h1));
        vecs.push_back(mk(8'h73, 0, 0, 1, 16'h1408, 4'h1));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h0000, 4'h3));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h3));
        vecs.push_back(mk(8'h83, 0, 0, 1, 16'h1408, 4'h3));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h0802, 4'h3));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h3));
        vecs.push_back(mk(8'h4C, 0, 0, 1, 16'h1408, 4'h3));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h4800, 4'hC));
        vecs.push_back(mk(8'h00, 0, 0, 3, 16'h2100, 4'hC));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'hC));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 16'h1408, 4'hC));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h0110, 4'h0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h0));
        vecs.push_back(mk(8'h95, 0, 0, 1, 16'h1408, 4'h0));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h0000, 4'h5));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h5));
        vecs.push_back(mk(8'h1A, 0, 0, 1, 16'h1408, 4'h5));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h4800, 4'hA));
        vecs.push_back(mk(8'h00, 0, 0, 3, 16'h1200, 4'hA));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'hA));
        vecs.push_back(mk(8'h62, 0, 0, 1, 16'h1408, 4'hA));
        vecs.push_back(mk(8'h00, 0, 0, 2, 16'h0802, 4'h2));
        vecs.push_back(mk(8'h00, 0, 0, 0, 16'h4004, 4'h2));

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_ctrl", ctrl, 16'h0000);
        end
        chk("reset_step", step, 3'd0);
        chk("reset_ack", step_ack, 1'b0);
        chk("reset_ctrl12", ctrl12, 16'h0000);
        next_cycle();
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus_in = vecs[i].bus; carry_in = vecs[i].c; zero_in = vecs[i].z;
            @(negedge clock);
            chk($sformatf("row%0d_ctrl", i), ctrl, vecs[i].ct);
            chk($sformatf("row%0d_step", i), step, vecs[i].st);
            chk($sformatf("row%0d_operand", i), operand, vecs[i].op);
            next_cycle();
        end
        carry_in = 0; zero_in = 0;

        bus_in = 8'hF0;
        @(negedge clock);
        chk("hlt_t1", ctrl, 16'h1408);
        next_cycle();
        bus_in = 8'h00;
        @(negedge clock);
        chk("hlt_t2", ctrl, 16'h8000);
        chk("hlt_t2_halted", halted, 1'b0);
        next_cycle();
        @(negedge clock);
        chk("halted_set", halted, 1'b1);
        chk("halted_ctrl", ctrl, 16'h8000);
        chk("halted_step", step, 3'd0);
        hs  = step;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            next_cycle();
            @(negedge clock);
            if (step !== hs || ctrl !== 16'h8000 || step_ack !== 1'b0 || halted !== 1'b1) bad++;
        end
        chk("halt_frozen_cycles_bad", bad, 0);

        next_cycle();
        reset = 1'b1;
        #2;
        chk("async_rst_ctrl", ctrl, 16'h0000);
        chk("async_rst_halted", halted, 1'b0);
        chk("async_rst_step", step, 3'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ctrl", ctrl, 16'h4004);
        chk("post_rst_step", step, 3'd0);

        // Single-step: LDI 5 (T0,T1,T2), then T0 of an ADD, then its T1 before switching back to free run.
        next_cycle();
        reset = 1'b1; step_mode = 1'b1; step_req = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("ss_idle_ctrl", ctrl, 16'h0000);
        chk("ss_idle_step", step, 3'd0);
        next_cycle();

        ss_pre = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        ss_ct  = '{16'h4004, 16'h1408, 16'h0A00, 16'h4004};
        ss_bus = '{8'h00, 8'h55, 8'h00, 8'h00};
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 8; c++) begin
                step_req = (c < 3);
                bus_in   = ss_bus[p];
                @(negedge clock);
                chk($sformatf("ss_p%0d_c%0d_ctrl", p, c), ctrl, (c == 0) ? ss_ct[p] : 16'h0000);
                chk($sformatf("ss_p%0d_c%0d_ack", p, c), step_ack, (c >= 1 && c <= 3));
                chk($sformatf("ss_p%0d_c%0d_step", p, c), step, (c == 0) ? ss_pre[p] : ss_pre[p+1]);
                next_cycle();
            end
        end
        chk("ss_operand", operand, 4'h5);

        for (int c = 0; c < 8; c++) begin
            step_req = (c < 3);
            bus_in   = 8'h2E;
            @(negedge clock);
            chk($sformatf("ss_add_c%0d_ctrl", c), ctrl, (c == 0) ? 16'h1408 : 16'h0000);
            chk($sformatf("ss_add_c%0d_step", c), step, (c == 0) ? 3'd1 : 3'd2);
            next_cycle();
        end

        step_mode = 1'b0; step_req = 1'b0; bus_in = 8'h00; carry_in = 1'b0;
        fr_ct = '{16'h4800, 16'h1020, 16'h0281, 16'h4004};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("switch_%0d_ctrl", i), ctrl, fr_ct[i]);
            chk($sformatf("switch_%0d_step", i), step, (i == 3) ? 3'd0 : 3'(i + 2));
            next_cycle();
        end

        reset12 = 1'b0;
        @(negedge clock);
        chk("w12_t0_ctrl", ctrl12, 16'h4004);
        chk("w12_t0_step", step12, 3'd0);
        next_cycle();
        bus12 = 12'h1AB;
        @(negedge clock);
        chk("w12_t1_ctrl", ctrl12, 16'h1408);
        next_cycle();
        bus12 = 12'h000;
        @(negedge clock);
        chk("w12_t2_ctrl", ctrl12, 16'h4800);
        chk("w12_operand", operand12, 8'hAB);
        next_cycle();
        @(negedge clock);
        chk("w12_t3_ctrl", ctrl12, 16'h1200);
        chk("w12_t3_step", step12, 3'd3);
        next_cycle();
        @(negedge clock);
        chk("w12_wrap_step", step12, 3'd0);
        chk("w12_wrap_ctrl", ctrl12, 16'h4004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_control_unit.md
# sap_control_unit

Parametrised instruction register, flags register, microstep sequencer and microcode decoder for the SAP-style computer. Each cycle it drives one control word to the bus-attached blocks: PC, MAR, RAM, A, B, ALU and output register. Compared with the fixed five-step 8-bit sequencer, it adds:

- parametrised data and opcode widths
- early instruction termination
- conditional jumps on latched flags
- sticky halt
- a single-step debug mode with a request/acknowledge handshake

## Interface

**Parameters**

- `DATA_W`, default 8: bus width. Must satisfy `DATA_W > OPCODE_W`.
- `OPCODE_W`, default 4: opcode field width. The opcode is the upper bits of the IR; the operand is the remaining lower bits. Must be at least 4.
- `STEPS`, default 5: microsteps per instruction (T0..T(STEPS-1)). Must be at least 5. The counter width is `$clog2(STEPS)`.

**Ports**

- `clock`, input, 1: system clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `bus_in`, input, `DATA_W`: shared bus value. Loaded into the IR when II is asserted.
- `carry_in`, input, 1: ALU carry. Latched when FI is asserted.
- `zero_in`, input, 1: ALU zero. Latched when FI is asserted.
- `step_mode`, input, 1: 1 selects single-step mode; 0 selects free run.
- `step_req`, input, 1: single-step request level.
- `step_ack`, output, 1: single-step acknowledge.
- `operand`, output, `DATA_W-OPCODE_W`: IR lower field, driven to the bus while IO is asserted.
- `ctrl`, output, 16: control word. Bit order is HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI (bit 15 down to bit 0).
- `step`, output, `$clog2(STEPS)`: current microstep, for debug display.
- `halted`, output, 1: sticky halt flag.

## Operation

**Opcodes.** Any opcode not listed below decodes as NOP.

- 0: NOP
- 1: LDA
- 2: ADD
- 3: SUB
- 4: STA
- 5: LDI
- 6: JMP
- 7: JC
- 8: JZ
- 14: OUT
- 15: HLT

**Microcode.** Fetch is common to every instruction:

- T0: CO MI
- T1: RO II CE

Per-opcode steps:

- LDA: T2 IO MI; T3 RO AI
- ADD: T2 IO MI; T3 RO BI; T4 EO AI FI
- SUB: as ADD, plus SU at T4
- STA: T2 IO MI; T3 AO RI
- LDI: T2 IO AI
- JMP: T2 IO J
- JC: T2 IO J, only if the latched carry is 1; otherwise T2 is empty
- JZ: T2 IO J, only if the latched zero is 1; otherwise T2 is empty
- OUT: T2 AO OI
- HLT: T2 HLT

**Early termination.** At the last non-empty step of an instruction, the next step is T0 rather than the remaining empty steps. A NOP, or a JC/JZ whose condition fails, ends after T2. The counter also wraps to T0 after T(STEPS-1).

**Registers.**

- IR loads `bus_in` on a rising edge while II is asserted.
- The flags register loads `{carry_in, zero_in}` on a rising edge while FI is asserted.

**Halt.** Halt sets on the edge that ends an HLT T2 and stays set until `reset`. While halted:

- `ctrl` drives only the HLT bit (16'h8000)
- the step counter is frozen
- `step_ack` is held at 0

**Single-step mode** (`step_mode` = 1):

- The sequencer advances exactly one microstep per request, on a rising edge of `step_req`. The edge is detected from a registered copy of `step_req`.
- `step_ack` rises on the edge that performs the advance and falls on the first edge after `step_req` is low.
- The control word is active, and the IR and flags load, only on the advancing cycle. In every other cycle `ctrl` is 0.
- If `step_mode` changes mid-instruction, the step counter is kept and no microstep is lost or repeated.

## Timing

- Control word and `operand` are combinational from IR, step, flags, the halted flag and the advance-enable. There is no registered delay.
- A register load takes effect on the edge that ends the step asserting it.
- Free run, step sequence:
  - LDI: T0, T1, T2, then T0. 3 cycles.
  - ADD: 5 cycles.
  - NOP: 3 cycles.
- A flags update at ADD T4 is visible to a JC/JZ fetched immediately afterwards.
- While `reset` is high, and immediately after it is released:
  - `ctrl` = 0 (forced while `reset` is high)
  - `step` = 0, IR = 0, flags = 0, `halted` = 0, `step_ack` = 0
  - the registered copy of `step_req` = 0
- The first cycle after `reset` falls is T0 (CO MI).
- Asserting `reset` in any state, including halted or mid-step, returns to these values immediately, without waiting for a clock edge.

## Structure

- Shared package `sap_pkg`:
  - opcode constants
  - control-bit index constants (`CTRL_HLT` .. `CTRL_FI`)
  - control-word width `CTRL_W` = 16
- One sub-module, `sap_microcode_rom`: a purely combinational mapping from (opcode, step, carry, zero) to (control word, last-step). It is instantiated once.
- The step counter, IR, flags, halt flag and single-step handshake logic live in the top level.

## Test plan

1. **Reset.** Hold `reset` for 3 cycles, then release.
   - During reset: `ctrl` = 0.
   - First cycle after release: `ctrl` = CO|MI, `step` = 0.
2. **LDI 7.** Drive `bus_in` = 8'h57 in T1.
   - IR = 8'h57 after the T1 edge.
   - `operand` = 4'h7.
   - T2 `ctrl` = IO|AI.
   - Next step is T0, 3 cycles total.
3. **ADD with flag, then JC.** Run ADD with `carry_in` = 1 at T4, then fetch JC (IR 8'h73).
   - ADD T4 `ctrl` = EO|AI|FI.
   - JC T2 `ctrl` = IO|J.
   - Repeating with `carry_in` = 0: JC T2 `ctrl` = 0, then T0.
4. **HLT.** Fetch IR 8'hF0.
   - T2 `ctrl` = HLT.
   - Afterwards: `halted` = 1, `ctrl` = 16'h8000, `step` frozen for more than 20 cycles.
   - A reset pulse clears `halted` and returns to T0.
5. **Single-step.** `step_mode` = 1 with 4 `step_req` pulses, each 3 cycles high and 5 low.
   - Exactly 4 step advances.
   - `step_ack` high from each advancing edge until `step_req` is low.
   - `ctrl` nonzero only on the advancing cycles.
   - Switching to `step_mode` = 0 at T2 continues from T2 with no lost or repeated step.
6. **Width generality.** Instantiate `DATA_W` = 12, `OPCODE_W` = 4, `STEPS` = 8. Run LDA with IR 12'h1AB.
   - `operand` = 8'hAB.
   - T2 `ctrl` = IO|MI; T3 `ctrl` = RO|AI.
   - The step counter returns to T0 after T3.
